// File: rtl/hack_screen_pkg.sv
// Shared screen-buffer geometry and the scanout sequencer state encoding.
package hack_screen_pkg;

  localparam int unsigned SCREEN_WORDS    = 8192;
  localparam int unsigned WORDS_PER_ROW   = 32;
  localparam int unsigned PIXELS_PER_WORD = 16;
  localparam int unsigned ADDR_W          = 13;
  localparam int unsigned DATA_W          = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StCapture,
    StShift
  } scan_state_e;

endpackage

// File: rtl/hack_pixel_serializer.sv
// Serialises one screen word LSB-first over a valid/ready pixel stream.
module hack_pixel_serializer #(
  parameter int unsigned DATA_W = hack_screen_pkg::PIXELS_PER_WORD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      pix_ready,
  output logic                      pix_valid,
  output logic                      pix_data,
  output logic [$clog2(DATA_W)-1:0] bit_idx,
  output logic                      last_bit
);

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q;
  logic [IdxW-1:0]   idx_q;
  logic              valid_q;
  logic              xfer;

  assign xfer     = valid_q & pix_ready;
  assign last_bit = xfer & (idx_q == LastIdx);

  // Shift and index only move on a transfer, so data and flags hold while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      shift_q <= {1'b0, shift_q[DATA_W-1:1]};
      idx_q   <= idx_q + IdxW'(1);
      if (idx_q == LastIdx) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign pix_valid = valid_q;
  assign pix_data  = valid_q & shift_q[0];
  assign bit_idx   = idx_q;

endmodule

// File: rtl/hack_screen_scanout.sv
// Owns screen-buffer port B: streams frames out as pixels or fills the buffer with a word.
module hack_screen_scanout #(
  parameter int unsigned ADDR_W        = hack_screen_pkg::ADDR_W,
  parameter int unsigned DATA_W        = hack_screen_pkg::DATA_W,
  parameter int unsigned WORDS_PER_ROW = hack_screen_pkg::WORDS_PER_ROW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_value,
  output logic [ADDR_W-1:0] addr_b,
  output logic              load_b,
  output logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] out_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              clear_done
);

  import hack_screen_pkg::*;

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam int unsigned RowW = $clog2(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] LastWord = '1;
  localparam logic [RowW-1:0]   LastCol  = '1;
  localparam logic [IdxW-1:0]   LastBit  = IdxW'(DATA_W - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              clear_any;
  logic              shift_load;
  logic              ser_valid;
  logic              ser_data;
  logic              last_bit;
  logic [IdxW-1:0]   bit_idx;

  assign clear_any = pend_q | clear_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    pend_d     = pend_q | (clear_req & busy);
    done_d     = 1'b0;
    shift_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Clear has priority; a simultaneous start is dropped, not queued.
        if (clear_any) begin
          state_d = StClear;
          cnt_d   = '0;
          fill_d  = clear_value;
          pend_d  = 1'b0;
        end else if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == LastWord) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      StFetch:   state_d = StCapture;
      StCapture: begin
        shift_load = 1'b1;
        state_d    = StShift;
      end
      StShift: begin
        if (last_bit) begin
          if (cnt_q != LastWord) begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = StFetch;
          end else if (clear_any) begin
            state_d = StClear;
            cnt_d   = '0;
            fill_d  = clear_value;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  hack_pixel_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .load      (shift_load),
    .load_data (out_b),
    .pix_ready (pix_ready),
    .pix_valid (ser_valid),
    .pix_data  (ser_data),
    .bit_idx   (bit_idx),
    .last_bit  (last_bit)
  );

  // The counter only moves in CLEAR/FETCH paths, so it doubles as the held port-B address.
  assign addr_b     = cnt_q;
  assign load_b     = (state_q == StClear);
  assign in_b       = fill_q;
  assign busy       = (state_q != StIdle);
  assign clear_done = done_q;
  assign pix_valid  = ser_valid;
  assign pix_data   = ser_data;
  assign pix_sof    = ser_valid & (cnt_q == '0) & (bit_idx == '0);
  assign pix_eol    = ser_valid & (cnt_q[RowW-1:0] == LastCol) & (bit_idx == LastBit);
  assign pix_eof    = ser_valid & (cnt_q == LastWord) & (bit_idx == LastBit);

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Self-checking bench for hack_screen_scanout on a reduced 256-word screen buffer.
module tb_hack_screen_scanout;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned WPR = 32;
  localparam int NW     = 1 << AW;
  localparam int NPIX   = NW * DW;
  localparam int ROWPIX = WPR * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          clear_req = 1'b0;
  logic          pix_ready = 1'b1;
  logic [DW-1:0] clear_value = '0;
  logic [AW-1:0] addr_b;
  logic          load_b;
  logic [DW-1:0] in_b;
  logic [DW-1:0] out_b;
  logic          pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy, clear_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  hack_screen_scanout #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .WORDS_PER_ROW (WPR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .clear_req   (clear_req),
    .clear_value (clear_value),
    .addr_b      (addr_b),
    .load_b      (load_b),
    .in_b        (in_b),
    .out_b       (out_b),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Screen buffer model with a registered read port and a bench preload port.
  logic [DW-1:0] mem [NW];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (load_b) mem[addr_b] <= in_b;
    out_b <= mem[addr_b];
  end

  // Monitor: pixel transfers {data,sof,eol,eof}, buffer writes, clear_done and stall holds.
  logic [3:0]    cap[$];
  int            wr_addr[$];
  int            wr_cyc[$];
  logic [DW-1:0] wr_data[$];
  int eof_cnt = 0, eof_cyc = 0, sof_cyc = 0, hold_err = 0, val_cnt = 0;
  int done_cnt = 0, done_cyc = 0;
  logic done_busy = 1'b0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_vec = '0;
  logic [3:0] vec;
  assign vec = {pix_data, pix_sof, pix_eol, pix_eof};

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!pix_valid || vec !== prev_vec)) hold_err++;
      if (pix_valid) val_cnt++;
      if (pix_valid && pix_ready) begin
        cap.push_back(vec);
        if (pix_sof) sof_cyc = cyc;
        if (pix_eof) begin
          eof_cnt++;
          eof_cyc = cyc;
        end
      end
      if (load_b) begin
        wr_addr.push_back(int'(addr_b));
        wr_data.push_back(in_b);
        wr_cyc.push_back(cyc);
      end
      if (clear_done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_vec   = vec;
    end
  end

  // Reference: raster order, row-major 512-pixel rows, LSB of each word is leftmost.
  logic [3:0] exp_vec [NPIX];
  function automatic void build_expected();
    int r, c, w, b;
    for (int p = 0; p < NPIX; p++) begin
      r = p / ROWPIX;
      c = p % ROWPIX;
      w = r * WPR + c / DW;
      b = c % DW;
      exp_vec[p] = {mem[w][b], p == 0, c == ROWPIX - 1, p == NPIX - 1};
    end
  endfunction

  task automatic preload(input int mode);
    for (int i = 0; i < NW; i++) begin
      @(posedge clock); #1;
      pre_we   = 1'b1;
      pre_addr = AW'(i);
      if (mode == 1) pre_data = (i == 0) ? 16'h0001 : (i == WPR - 1) ? 16'h8000 : 16'h0000;
      else pre_data = DW'($urandom);
    end
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_scan(input bit rnd, input int clr_at, output bit to, output int c0,
                          output int base);
    int e0;
    base = cap.size();
    e0   = eof_cnt;
    build_expected();
    @(posedge clock); #1;
    start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    c0 = cyc;
    to = 1'b1;
    for (int n = 0; n < 6 * NPIX; n++) begin
      if (eof_cnt != e0) begin
        to = 1'b0;
        break;
      end
      if (rnd) pix_ready = ($urandom_range(0, 1) == 1);
      clear_req = (n == clr_at);
      @(posedge clock); #1;
    end
    pix_ready = 1'b1;
    clear_req = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    int d0;
    d0 = done_cnt;
    to = 1'b1;
    for (int n = 0; n < 4 * NW; n++) begin
      if (done_cnt != d0) begin
        to = 1'b0;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({addr_b, load_b, in_b, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy,
         clear_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%0h load=%0b in=%0h valid=%0b busy=%0b done=%0b want all 0",
               addr_b, load_b, in_b, pix_valid, busy, clear_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_scan_pattern();
    bit to;
    int c0, base, bad;
    preload(1);
    run_scan(1'b0, -1, to, c0, base);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL pat_timeout: got %0b want 0", to); end
    n_cmp++;
    if (cap.size() - base !== NPIX) begin
      n_bad++; $display("FAIL pat_count: got %0d want %0d", cap.size() - base, NPIX);
    end
    if (cap.size() - base >= NPIX) begin
      n_cmp++;
      if (cap[base] !== 4'b1100) begin
        n_bad++; $display("FAIL pat_first_pixel: got %b want 1100", cap[base]);
      end
      n_cmp++;
      if (cap[base + ROWPIX - 1] !== 4'b1010) begin
        n_bad++; $display("FAIL pat_pixel511: got %b want 1010", cap[base + ROWPIX - 1]);
      end
      bad = 0;
      for (int i = 1; i < ROWPIX - 1; i++) if (cap[base + i][3] !== 1'b0) bad++;
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL pat_row0_zero: got %0d ones want 0", bad); end
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (cap[base + i] !== exp_vec[i]) bad++;
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL pat_frame: got %0d bad pixels want 0", bad); end
    end
    n_cmp++;
    if (sof_cyc !== c0 + 2) begin
      n_bad++; $display("FAIL pat_first_latency: got %0d want %0d", sof_cyc - c0 + 1, 3);
    end
    n_cmp++;
    if (eof_cyc !== c0 + 18 * NW - 1) begin
      n_bad++; $display("FAIL pat_frame_cycles: got %0d want %0d", eof_cyc - c0 + 1, 18 * NW);
    end
    n_cmp++;
    if ((eof_cyc - sof_cyc + 1) - NPIX !== 2 * (NW - 1)) begin
      n_bad++; $display("FAIL pat_gaps: got %0d want %0d", (eof_cyc - sof_cyc + 1) - NPIX, 2 * (NW - 1));
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL pat_idle_after: got %0b want 0", busy); end
  endtask

  task automatic test_random_ready();
    bit to;
    int c0, base, bad, h0;
    preload(2);
    h0 = hold_err;
    run_scan(1'b1, -1, to, c0, base);
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL rnd_timeout: got %0b want 0", to); end
    n_cmp++;
    if (cap.size() - base !== NPIX) begin
      n_bad++; $display("FAIL rnd_count: got %0d want %0d", cap.size() - base, NPIX);
    end
    if (cap.size() - base >= NPIX) begin
      bad = 0;
      for (int i = 0; i < NPIX; i++) if (cap[base + i] !== exp_vec[i]) bad++;
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL rnd_frame: got %0d bad pixels want 0", bad); end
    end
    n_cmp++;
    if (hold_err - h0 !== 0) begin
      n_bad++; $display("FAIL rnd_hold: got %0d changes while stalled want 0", hold_err - h0);
    end
  endtask

  task automatic test_clear();
    bit to;
    int c0, w0, d0, base, bad;
    clear_value = 16'hFFFF;
    w0 = wr_addr.size();
    d0 = done_cnt;
    @(posedge clock); #1;
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    c0 = cyc;
    wait_done(to);
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL clr_timeout: got %0b want 0", to); end
    n_cmp++;
    if (wr_addr.size() - w0 !== NW) begin
      n_bad++; $display("FAIL clr_writes: got %0d want %0d", wr_addr.size() - w0, NW);
    end
    if (wr_addr.size() - w0 >= NW) begin
      bad = 0;
      for (int i = 0; i < NW; i++)
        if (wr_addr[w0 + i] !== i || wr_data[w0 + i] !== 16'hFFFF || wr_cyc[w0 + i] !== c0 + i) bad++;
      n_cmp++;
      if (bad !== 0) begin n_bad++; $display("FAIL clr_sequence: got %0d bad writes want 0", bad); end
    end
    n_cmp++;
    if (done_cyc !== c0 + NW) begin
      n_bad++; $display("FAIL clr_done_cycle: got %0d want %0d", done_cyc - c0, NW);
    end
    n_cmp++;
    if (done_busy !== 1'b0) begin n_bad++; $display("FAIL clr_done_busy: got %0b want 0", done_busy); end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL clr_done_pulses: got %0d want 1", done_cnt - d0); end
    run_scan(1'b0, -1, to, c0, base);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (base + i >= cap.size() || cap[base + i][3] !== 1'b1) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL clr_scan_ones: got %0d non-1 pixels want 0", bad); end
  endtask

  task automatic test_start_and_clear();
    bit to;
    int v0, w0, bad;
    logic [DW-1:0] v;
    v = DW'($urandom);
    clear_value = v;
    v0 = val_cnt;
    w0 = wr_addr.size();
    @(posedge clock); #1;
    start = 1'b1;
    clear_req = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    clear_req = 1'b0;
    wait_done(to);
    repeat (20) @(posedge clock);
    #1;
    n_cmp++;
    if (to !== 1'b0) begin n_bad++; $display("FAIL both_timeout: got %0b want 0", to); end
    n_cmp++;
    if (val_cnt - v0 !== 0) begin n_bad++; $display("FAIL both_no_scan: got %0d valid cycles want 0", val_cnt - v0); end
    n_cmp++;
    if (wr_addr.size() - w0 !== NW) begin
      n_bad++; $display("FAIL both_writes: got %0d want %0d", wr_addr.size() - w0, NW);
    end
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== v) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL both_fill: got %0d bad words want 0", bad); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL both_idle: got %0b want 0", busy); end
  endtask

  task automatic test_clear_during_scan();
    bit to, to2;
    int c0, w0, base, bad;
    logic [DW-1:0] v;
    preload(2);
    v = DW'($urandom);
    clear_value = v;
    w0 = wr_addr.size();
    run_scan(1'b0, 300, to, c0, base);
    wait_done(to2);
    n_cmp++;
    if ((to | to2) !== 1'b0) begin n_bad++; $display("FAIL mid_clr_timeout: got %0b%0b want 00", to, to2); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (base + i >= cap.size() || cap[base + i] !== exp_vec[i]) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL mid_clr_frame: got %0d bad pixels want 0", bad); end
    n_cmp++;
    if (wr_addr.size() - w0 !== NW) begin
      n_bad++; $display("FAIL mid_clr_writes: got %0d want %0d", wr_addr.size() - w0, NW);
    end
    if (wr_addr.size() > w0) begin
      n_cmp++;
      if (wr_cyc[w0] !== eof_cyc + 1 || wr_addr[w0] !== 0) begin
        n_bad++;
        $display("FAIL mid_clr_start: got cycle +%0d addr %0d want +1 addr 0", wr_cyc[w0] - eof_cyc, wr_addr[w0]);
      end
    end
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== v) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL mid_clr_fill: got %0d bad words want 0", bad); end
  endtask

  task automatic test_reset_mid_scan();
    bit to, hit;
    int c0, w0, base, bad;
    preload(2);
    hit = 1'b0;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (addr_b == AW'(100)) begin
        hit = 1'b1;
        break;
      end
      clear_req = (n == 50);
      @(posedge clock); #1;
    end
    clear_req = 1'b0;
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL rst_scan_reach: got %0b want 1", hit); end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({addr_b, load_b, in_b, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy,
         clear_done} !== '0) begin
      n_bad++;
      $display("FAIL rst_scan_outputs: got addr=%0h load=%0b in=%0h valid=%0b busy=%0b want all 0",
               addr_b, load_b, in_b, pix_valid, busy);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    w0 = wr_addr.size();
    repeat (10) @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || wr_addr.size() !== w0) begin
      n_bad++; $display("FAIL rst_scan_pending: got busy=%0b writes=%0d want 0 0", busy, wr_addr.size() - w0);
    end
    run_scan(1'b0, -1, to, c0, base);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (base + i >= cap.size() || cap[base + i] !== exp_vec[i]) bad++;
    n_cmp++;
    if ((bad !== 0) || to) begin n_bad++; $display("FAIL rst_scan_rescan: got %0d bad pixels want 0", bad); end
    n_cmp++;
    if (sof_cyc !== c0 + 2) begin n_bad++; $display("FAIL rst_scan_sof: got %0d want %0d", sof_cyc - c0, 2); end
  endtask

  task automatic test_reset_mid_clear();
    bit to, hit;
    int c0, base, bad;
    logic [DW-1:0] v;
    logic [DW-1:0] old [NW];
    for (int i = 0; i < NW; i++) old[i] = mem[i];
    v = DW'($urandom);
    clear_value = v;
    hit = 1'b0;
    @(posedge clock); #1;
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (addr_b == AW'(200) && load_b) begin
        hit = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL rst_clr_reach: got %0b want 1", hit); end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({addr_b, load_b, in_b, pix_valid, pix_data, pix_sof, pix_eol, pix_eof, busy,
         clear_done} !== '0) begin
      n_bad++;
      $display("FAIL rst_clr_outputs: got addr=%0h load=%0b in=%0h busy=%0b done=%0b want all 0",
               addr_b, load_b, in_b, busy, clear_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ((i < 200) ? v : old[i])) bad++;
    n_cmp++;
    if (bad !== 0) begin n_bad++; $display("FAIL rst_clr_partial: got %0d bad words want 0", bad); end
    run_scan(1'b0, -1, to, c0, base);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (base + i >= cap.size() || cap[base + i] !== exp_vec[i]) bad++;
    n_cmp++;
    if ((bad !== 0) || to) begin n_bad++; $display("FAIL rst_clr_rescan: got %0d bad pixels want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_scan_pattern();
    test_random_ready();
    test_clear();
    test_start_and_clear();
    test_clear_during_scan();
    test_reset_mid_scan();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
